aes128_enc_round_seq: RTL
=========================

# aes128_enc_round_seq

Iterative AES-128 encryption sequencer: accepts one 128-bit plaintext block per transaction, runs the initial AddRoundKey plus ROUNDS cipher rounds at one round per clock, and returns the ciphertext over a valid/ready handshake. It owns the 128-bit state register and the round counter, and instantiates `mix_columns` internally. SubBytes+ShiftRows is an external combinational path wired through ports. Round keys come from an external precomputed key store indexed by `rk_idx`. It sits between the block-cipher front end and the key-expansion store.

## Interface
- `ROUNDS`, default 10, number of cipher rounds; legal 2..15; AES-128 requires 10.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  plaintext offered.
- `in_ready`  out  1  sequencer can accept plaintext.
- `in_data`  in  128  plaintext, byte 0 at [127:120], column-major (4 bytes per column).
- `rk_idx`  out  4  round-key index requested this cycle.
- `rk_data`  in  128  round key for `rk_idx`, valid combinationally in the same cycle.
- `sb_in`  out  128  state fed to the external SubBytes+ShiftRows path (always equals the state register).
- `sb_out`  in  128  SubBytes+ShiftRows result of `sb_in`, combinational.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  128  ciphertext (equals the state register).
- `busy`  out  1  high in ROUND and DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `rk_idx`=0.
  - ROUND: `rk_idx`=round counter r (1..ROUNDS).
  - DONE: `out_valid`=1, `rk_idx`=0.
- IDLE, `in_valid`&`in_ready`: state <= `in_data` ^ `rk_data` (key 0); r <= 1; go to ROUND.
- ROUND, r < ROUNDS: state <= mix_columns(`sb_out`) ^ `rk_data`; r <= r+1.
- ROUND, r == ROUNDS: state <= `sb_out` ^ `rk_data` (MixColumns skipped); go to DONE.
- DONE: hold state and `out_data` stable while `out_valid`=1 and `out_ready`=0. On `out_ready`=1, go to IDLE.
- No input acceptance in DONE: `in_ready`=0 outside IDLE, including the cycle in which the output is consumed.
- `in_data` and `in_valid` are ignored outside IDLE. `out_ready` is ignored outside DONE.
- Round counter is 4 bits. It never wraps, since ROUNDS ≤ 15, and it is don't-care outside ROUND. It resets to 0.
- All XORs are 128-bit bitwise with no width extension. MixColumns uses the column-major byte mapping defined for `in_data`.

## Timing
- Reset values, asynchronous on `rst_n`=0: FSM=IDLE, state=0, r=0. Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `rk_idx`=0, `out_data`=0, `sb_in`=0.
- Reset mid-operation (ROUND or DONE) aborts the block immediately. It returns to IDLE with no output produced and the state cleared.
- Latency: accept at edge E0; rounds complete at edges E1..E(ROUNDS); `out_valid` rises after E(ROUNDS). For ROUNDS=10 that is 10 cycles after the accepting edge.
- Throughput: one block per ROUNDS+2 cycles when `out_ready` is held high: accept, ROUNDS rounds, one DONE cycle.
- `out_valid` must not drop without a handshake. `out_data` must not change while `out_valid`=1.
- `rk_idx`, `in_ready`, `out_valid` and `busy` are decoded from registered state only. They must not depend combinationally on any input.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, `out_ready`=1 → `out_valid` 10 cycles after accept, `out_data`=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Check that `rk_idx` steps 0,1,…,10 on consecutive cycles.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `out_data` stable, `in_ready`=0, second `in_valid` ignored. Release → handshake completes, `in_ready`=1 on the next cycle.
- Back-to-back: two blocks offered continuously with `out_ready`=1 → both ciphertexts correct, second accepted exactly 12 cycles after the first.
- Reset abort: assert `rst_n`=0 at round 5 → all outputs at reset values immediately. A following App. B transaction still produces 3925841d02dc09fbdc118597196a0b32.
- Reset idle: after reset with no stimulus → `in_ready`=1, `out_valid`=0, `busy`=0, `rk_idx`=0 held indefinitely.

Source files
------------

// File: rtl/aes128_enc_round_seq.sv
// Iterative AES-128 encryption sequencer: one cipher round per clock, with an external
// SubBytes+ShiftRows path and round-key store, and MixColumns computed internally.

module mix_columns (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c holds bytes 4c..4c+3, most significant byte first.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;
    assign w_a0 = i_state[127-32*c -: 8];
    assign w_a1 = i_state[119-32*c -: 8];
    assign w_a2 = i_state[111-32*c -: 8];
    assign w_a3 = i_state[103-32*c -: 8];
    assign o_state[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_state[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

module aes128_enc_round_seq #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(ROUNDS);

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] w_state_nxt;
  logic [127:0] w_mix;
  logic [3:0]   r_round;
  logic [3:0]   w_round_nxt;

  mix_columns u_mix (
    .i_state (sb_out),
    .o_state (w_mix)
  );

  // FSM, cipher state and round counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= 128'd0;
      r_round <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Next state: key-0 whitening on accept, full rounds, then a final round without MixColumns.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = in_data ^ rk_data;
          w_round_nxt = 4'd1;
          w_fsm_nxt   = S_ROUND;
        end else begin
          w_fsm_nxt   = S_IDLE;
        end
      end
      S_ROUND: begin
        if (r_round == LP_LAST) begin
          w_state_nxt = sb_out ^ rk_data;
          w_fsm_nxt   = S_DONE;
        end else begin
          w_state_nxt = w_mix ^ rk_data;
          w_round_nxt = r_round + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end else begin
          w_fsm_nxt = S_DONE;
        end
      end
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_state_nxt = 128'd0;
        w_round_nxt = 4'd0;
      end
    endcase
  end

  // Handshake and key index are decoded from registered state only.
  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm == S_ROUND) || (r_fsm == S_DONE);
  assign rk_idx    = (r_fsm == S_ROUND) ? r_round : 4'd0;
  assign sb_in     = r_state;
  assign out_data  = r_state;

endmodule
